regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite / rd_addr / rd_wdata) between two writeback sources: src0 (execute/ALU) and src1 (load unit).
- Fixed priority to src0, with a starvation guard that forces a src1 grant after a bounded wait.
- The winner is registered into a one-entry writeback stage that drives the register file on the following cycle.
- Provides rs1/rs2 forwarding from that stage so asynchronous reads in the same cycle see the in-flight value.

Parameters:
- ADDR_WIDTH, 5, register address width; must match the register file.
- DATA_WIDTH, 32, register data width.
- STARVE_LIMIT, 4, consecutive losing cycles for src1 after which src1 gets priority; must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of the writeback stage and the starvation counter
- src0_valid  in  1  src0 write request
- src0_ready  out  1  src0 granted this cycle
- src0_addr  in  ADDR_WIDTH  src0 destination register
- src0_data  in  DATA_WIDTH  src0 write data
- src1_valid  in  1  src1 write request
- src1_ready  out  1  src1 granted this cycle
- src1_addr  in  ADDR_WIDTH  src1 destination register
- src1_data  in  DATA_WIDTH  src1 write data
- RegWrite  out  1  register-file write enable
- rd_addr  out  ADDR_WIDTH  register-file write address
- rd_wdata  out  DATA_WIDTH  register-file write data
- rs1_addr  in  ADDR_WIDTH  read address 1 (same net as the register-file port)
- rs2_addr  in  ADDR_WIDTH  read address 2
- rs1_fwd  out  1  rs1 matches the in-flight write
- rs2_fwd  out  1  rs2 matches the in-flight write
- fwd_data  out  DATA_WIDTH  in-flight write data (equal to rd_wdata)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset (async assert) clears all state:
  - RegWrite=0, rd_addr=0, rd_wdata=0, starve_cnt=0.
  - rs1_fwd=rs2_fwd=0.
  - src*_ready are combinational and are 0 while rst is high.
- Grant (combinational, single winner):
  - starve = (starve_cnt ≥ STARVE_LIMIT).
  - g1 = src1_valid && (!src0_valid || starve).
  - g0 = src0_valid && !g1.
  - src0_ready=g0 and src1_ready=g1, both gated by !flush and !rst.
  - Ready never depends on the stage being empty: the stage drains every cycle, so sustained throughput is 1 write/cycle.
- Handshake:
  - A transfer occurs on valid && ready at the rising edge.
  - Sources hold addr/data stable while valid && !ready.
  - Once asserted, valid stays high until the transfer occurs.
- Writeback stage (registered, latency 1):
  - On a transfer, the stage loads {addr, data} from the winner.
  - RegWrite = 1 in the next cycle iff the winner's addr ≠ 0.
  - A transfer to x0 completes the handshake but loads RegWrite=0 (the write is dropped).
  - A cycle with no transfer loads RegWrite=0. rd_addr and rd_wdata hold their last values when RegWrite=0.
- Starvation counter (saturating at STARVE_LIMIT, width $clog2(STARVE_LIMIT+1)):
  - Set to 0 if !src1_valid, g1, or flush.
  - Otherwise, if src1_valid && !g1, increment by 1.
- flush:
  - Next state: RegWrite=0, starve_cnt=0.
  - No grants during the flush cycle.
  - A write already presented on RegWrite in the flush cycle still commits (the register file samples it on the same edge).
- Forwarding (combinational):
  - rs1_fwd = RegWrite && (rs1_addr == rd_addr) && (rs1_addr ≠ 0); rs2_fwd likewise.
  - fwd_data = rd_wdata.
  - The consumer muxes fwd_data over the register-file read when *_fwd=1.
- Ordering: both sources never target the same register in flight; no same-address ordering is enforced beyond grant order.
- Reset mid-operation: a pending write is discarded, and any un-granted requests are re-arbitrated after reset deasserts.

Test Plan:
- Reset, then src0_valid=1, addr=5, data=0xDEADBEEF -> src0_ready=1 that cycle; next cycle RegWrite=1, rd_addr=5, rd_wdata=0xDEADBEEF; the cycle after, RegWrite=0.
- src0 and src1 both valid continuously, STARVE_LIMIT=4 -> grants 0,0,0,0,1,0,0,0,0,1,…; src1 is granted in the 5th cycle, and starve_cnt returns to 0 after the grant.
- src1 alone valid, addr=0, data=0x1234 -> src1_ready=1; next cycle RegWrite=0; starve_cnt stays 0.
- Write addr=7, data=0xA5A5A5A5 granted; next cycle drive rs1_addr=7, rs2_addr=0 -> rs1_fwd=1, fwd_data=0xA5A5A5A5, rs2_fwd=0.
- flush asserted while both sources are valid and starve_cnt=3 -> src0_ready=src1_ready=0; next cycle RegWrite=0 and starve_cnt=0; src0 is granted the cycle after flush deasserts.
- Assert rst asynchronously mid-cycle while RegWrite=1 -> RegWrite drops immediately with no clock edge; after release the outputs hold their reset values until a new grant.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback sources (src0 = execute, src1 = load unit) share the single
// register-file write port. src0 normally wins; src1 is promoted after it has
// lost STARVE_LIMIT consecutive cycles. The winner is captured in a one-entry
// writeback stage that drives the register file on the next cycle. rs1/rs2
// forwarding flags let same-cycle asynchronous reads pick up that in-flight value.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4   // must be >= 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  src0_valid,
  output logic                  src0_ready,
  input  logic [ADDR_WIDTH-1:0] src0_addr,
  input  logic [DATA_WIDTH-1:0] src0_data,
  input  logic                  src1_valid,
  output logic                  src1_ready,
  input  logic [ADDR_WIDTH-1:0] src1_addr,
  input  logic [DATA_WIDTH-1:0] src1_data,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_wdata,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  // Counter just wide enough to hold STARVE_LIMIT; it saturates there.
  localparam int                  CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] X0  = '0;

  // Writeback stage and starvation state
  logic                  r_regwrite;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd_wdata;
  logic [CNT_W-1:0]      r_starve_cnt;

  // Arbitration and next-state wires
  logic                  w_starve;
  logic                  w_g0;
  logic                  w_g1;
  logic                  w_grant_en;
  logic                  w_xfer0;
  logic                  w_xfer1;
  logic                  w_regwrite_next;
  logic [ADDR_WIDTH-1:0] w_rd_addr_next;
  logic [DATA_WIDTH-1:0] w_rd_wdata_next;
  logic [CNT_W-1:0]      w_starve_cnt_next;

  // Single-winner grant: src0 by default, src1 when alone or once starved.
  // Grants never wait on the stage, since it drains every cycle.
  always_comb begin
    w_starve   = (r_starve_cnt >= LIMIT);
    w_g1       = src1_valid && (!src0_valid || w_starve);
    w_g0       = src0_valid && !w_g1;
    w_grant_en = !flush && !rst;
    src0_ready = w_g0 && w_grant_en;
    src1_ready = w_g1 && w_grant_en;
    w_xfer0    = src0_valid && src0_ready;
    w_xfer1    = src1_valid && src1_ready;
  end

  // Next writeback-stage contents: load the winner, drop writes to x0,
  // and hold address/data when nothing transfers.
  always_comb begin
    w_regwrite_next = 1'b0;
    w_rd_addr_next  = r_rd_addr;
    w_rd_wdata_next = r_rd_wdata;
    if (w_xfer1) begin
      w_regwrite_next = (src1_addr != X0);
      w_rd_addr_next  = src1_addr;
      w_rd_wdata_next = src1_data;
    end else if (w_xfer0) begin
      w_regwrite_next = (src0_addr != X0);
      w_rd_addr_next  = src0_addr;
      w_rd_wdata_next = src0_data;
    end
  end

  // Starvation counter: counts consecutive cycles src1 waits without a grant,
  // cleared when src1 is idle, granted, or the pipeline is flushed.
  always_comb begin
    w_starve_cnt_next = r_starve_cnt;
    if (!src1_valid || w_g1 || flush) begin
      w_starve_cnt_next = '0;
    end else if (r_starve_cnt < LIMIT) begin
      w_starve_cnt_next = r_starve_cnt + CNT_W'(1);
    end
  end

  // State registers; reset discards any pending write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwrite   <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_wdata   <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_regwrite   <= w_regwrite_next;
      r_rd_addr    <= w_rd_addr_next;
      r_rd_wdata   <= w_rd_wdata_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  assign RegWrite = r_regwrite;
  assign rd_addr  = r_rd_addr;
  assign rd_wdata = r_rd_wdata;

  // Forwarding: x0 is never forwarded, even if it somehow matched.
  assign rs1_fwd  = r_regwrite && (rs1_addr == r_rd_addr) && (rs1_addr != X0);
  assign rs2_fwd  = r_regwrite && (rs2_addr == r_rd_addr) && (rs2_addr != X0);
  assign fwd_data = r_rd_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: a cycle-by-cycle vector table
// plus hand-written flush and asynchronous-reset sequences.
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          src0_valid, src1_valid;
  logic          src0_ready, src1_ready;
  logic [AW-1:0] src0_addr, src1_addr;
  logic [DW-1:0] src0_data, src1_data;
  logic          RegWrite;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_wdata;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic          rs1_fwd, rs2_fwd;
  logic [DW-1:0] fwd_data;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src0_addr(src0_addr), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready),
    .src1_addr(src1_addr), .src1_data(src1_data),
    .RegWrite(RegWrite), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
  );

  typedef struct {
    logic          flush;
    logic          s0v;
    logic [AW-1:0] s0a;
    logic [DW-1:0] s0d;
    logic          s1v;
    logic [AW-1:0] s1a;
    logic [DW-1:0] s1d;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          e_r0;
    logic          e_r1;
    logic          e_rw;
    logic          chk_d;   // compare rd_addr/rd_wdata/fwd_data this row
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_f1;
    logic          e_f2;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic f, input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    flush = f;
    src0_valid = v0; src0_addr = a0; src0_data = d0;
    src1_valid = v1; src1_addr = a1; src1_data = d1;
  endtask

  initial begin
    // Each row: inputs for one cycle; expected ready (this cycle) and stage
    // outputs (result of the previous row's transfer).
    //          fl s0v s0a s0d           s1v s1a s1d           rs1 rs2  r0 r1 rw cd addr data          f1 f2
    vecs[0]  = '{0, 0, 0, 32'h0,         0, 0, 32'h0,          0,  0,   0, 0, 0, 1, 0, 32'h0,         0, 0};
    vecs[1]  = '{0, 1, 5, 32'hDEADBEEF,  0, 0, 32'h0,          0,  0,   1, 0, 0, 1, 0, 32'h0,         0, 0};
    vecs[2]  = '{0, 0, 0, 32'h0,         0, 0, 32'h0,          5,  5,   0, 0, 1, 1, 5, 32'hDEADBEEF,  1, 1};
    vecs[3]  = '{0, 0, 0, 32'h0,         0, 0, 32'h0,          5,  0,   0, 0, 0, 1, 5, 32'hDEADBEEF,  0, 0};
    vecs[4]  = '{0, 0, 0, 32'h0,         1, 0, 32'h1234,       0,  0,   0, 1, 0, 1, 5, 32'hDEADBEEF,  0, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,         0, 0, 32'h0,          0,  0,   0, 0, 0, 0, 0, 32'h0,         0, 0};
    vecs[6]  = '{0, 0, 0, 32'h0,         1, 7, 32'hA5A5A5A5,   0,  0,   0, 1, 0, 0, 0, 32'h0,         0, 0};
    vecs[7]  = '{0, 0, 0, 32'h0,         0, 0, 32'h0,          7,  0,   0, 0, 1, 1, 7, 32'hA5A5A5A5,  1, 0};
    vecs[8]  = '{0, 1, 3, 32'h11,        1, 9, 32'h22,         7,  7,   1, 0, 0, 1, 7, 32'hA5A5A5A5,  0, 0};
    vecs[9]  = '{0, 1, 4, 32'h33,        1, 9, 32'h22,         3,  0,   1, 0, 1, 1, 3, 32'h11,        1, 0};
    vecs[10] = '{0, 1, 5, 32'h44,        1, 9, 32'h22,         0,  0,   1, 0, 1, 1, 4, 32'h33,        0, 0};
    vecs[11] = '{0, 1, 6, 32'h55,        1, 9, 32'h22,         0,  0,   1, 0, 1, 1, 5, 32'h44,        0, 0};
    vecs[12] = '{0, 1, 8, 32'h66,        1, 9, 32'h22,         0,  0,   0, 1, 1, 1, 6, 32'h55,        0, 0};
    vecs[13] = '{0, 1, 8, 32'h66,        0, 0, 32'h0,          9,  0,   1, 0, 1, 1, 9, 32'h22,        1, 0};
    vecs[14] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,          0,  8,   0, 0, 1, 1, 8, 32'h66,        0, 1};
    vecs[15] = '{0, 0, 0, 32'h0,         0, 0, 32'h0,          8,  0,   0, 0, 0, 1, 8, 32'h66,        0, 0};

    // Reset state, with a request pending to show ready is held low.
    rst = 1'b1;
    drive(0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    rs1_addr = '0; rs2_addr = '0;
    #2;
    check("reset_src0_ready", 32'(src0_ready), 32'd0);
    check("reset_src1_ready", 32'(src1_ready), 32'd0);
    check("reset_regwrite",   32'(RegWrite),   32'd0);
    check("reset_rd_addr",    32'(rd_addr),    32'd0);
    check("reset_rd_wdata",   rd_wdata,        32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].flush, vecs[i].s0v, vecs[i].s0a, vecs[i].s0d,
            vecs[i].s1v, vecs[i].s1a, vecs[i].s1d);
      rs1_addr = vecs[i].rs1;
      rs2_addr = vecs[i].rs2;
      @(negedge clk);
      check($sformatf("v%0d_src0_ready", i), 32'(src0_ready), 32'(vecs[i].e_r0));
      check($sformatf("v%0d_src1_ready", i), 32'(src1_ready), 32'(vecs[i].e_r1));
      check($sformatf("v%0d_regwrite", i),   32'(RegWrite),   32'(vecs[i].e_rw));
      check($sformatf("v%0d_rs1_fwd", i),    32'(rs1_fwd),    32'(vecs[i].e_f1));
      check($sformatf("v%0d_rs2_fwd", i),    32'(rs2_fwd),    32'(vecs[i].e_f2));
      if (vecs[i].chk_d) begin
        check($sformatf("v%0d_rd_addr", i),  32'(rd_addr),    32'(vecs[i].e_addr));
        check($sformatf("v%0d_rd_wdata", i), rd_wdata,        vecs[i].e_data);
        check($sformatf("v%0d_fwd_data", i), fwd_data,        vecs[i].e_data);
      end
    end

    // Flush with starve count at 3: three src0 wins, then flush.
    rs1_addr = '0; rs2_addr = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drive(0, 1, 5'(10 + 2 * k), 32'(100 + k), 1, 5'd11, 32'd200);
      @(negedge clk);
      check($sformatf("fl_pre%0d_src0_ready", k), 32'(src0_ready), 32'd1);
    end
    @(posedge clk); #1;
    drive(1, 1, 5'd14, 32'd103, 1, 5'd11, 32'd200);
    @(negedge clk);
    check("fl_src0_ready",   32'(src0_ready), 32'd0);
    check("fl_src1_ready",   32'(src1_ready), 32'd0);
    check("fl_regwrite_in",  32'(RegWrite),   32'd1);
    check("fl_rd_addr_in",   32'(rd_addr),    32'd14);
    @(posedge clk); #1;
    drive(0, 1, 5'd14, 32'd103, 1, 5'd11, 32'd200);
    @(negedge clk);
    check("fl_post_regwrite",   32'(RegWrite),   32'd0);
    check("fl_post_src0_ready", 32'(src0_ready), 32'd1);
    check("fl_post_src1_ready", 32'(src1_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive(0, 1, 5'(15 + k), 32'(104 + k), 1, 5'd11, 32'd200);
      @(negedge clk);
      check($sformatf("fl_run%0d_src0_ready", k), 32'(src0_ready), (k == 3) ? 32'd0 : 32'd1);
      check($sformatf("fl_run%0d_src1_ready", k), 32'(src1_ready), (k == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("fl_src1_regwrite", 32'(RegWrite), 32'd1);
    check("fl_src1_rd_addr",  32'(rd_addr),  32'd11);
    check("fl_src1_rd_wdata", rd_wdata,      32'd200);

    // Asynchronous reset while a write is on the port.
    @(posedge clk); #1;
    drive(0, 1, 5'd20, 32'hCAFEF00D, 0, 0, 0);
    @(negedge clk);
    check("ar_grant", 32'(src0_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 1, 5'd21, 32'h0000BEEF, 0, 0, 0);
    rs1_addr = 5'd20;
    check("ar_pre_regwrite", 32'(RegWrite), 32'd1);
    check("ar_pre_rd_addr",  32'(rd_addr),  32'd20);
    #1 rst = 1'b1;
    #1;
    check("ar_regwrite",   32'(RegWrite),   32'd0);
    check("ar_rd_addr",    32'(rd_addr),    32'd0);
    check("ar_rd_wdata",   rd_wdata,        32'd0);
    check("ar_rs1_fwd",    32'(rs1_fwd),    32'd0);
    check("ar_src0_ready", 32'(src0_ready), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("ar_rel_regwrite",   32'(RegWrite),   32'd0);
    check("ar_rel_rd_addr",    32'(rd_addr),    32'd0);
    check("ar_rel_src0_ready", 32'(src0_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rs1_addr = 5'd21;
    @(negedge clk);
    check("ar_new_regwrite", 32'(RegWrite), 32'd1);
    check("ar_new_rd_addr",  32'(rd_addr),  32'd21);
    check("ar_new_rd_wdata", rd_wdata,      32'h0000BEEF);
    check("ar_new_rs1_fwd",  32'(rs1_fwd),  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
